// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one SRAM port among NREQ engines (optional burst lock via ARB_LOCK_EN)
module sram_port_arbiter #(
    parameter int NREQ     = 3,
    parameter int LOCK_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_we,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      req_grant,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 S_R_req,
    output logic [31:0]          S_addr,
    input  logic [31:0]          S_R_data,
    output logic [3:0]           S_W_req,
    output logic [31:0]          S_W_data
);

    localparam int IDXW = $clog2(NREQ);

    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] win_idx;
    logic            win_found;
    logic [IDXW:0]   rr_choice;
    logic [3:0]      sel_we;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;

    logic            tag1_v;
    logic [IDXW-1:0] tag1_idx;
    logic            tag2_v;
    logic [IDXW-1:0] tag2_idx;

    // First valid requester at or after ptr, wrapping; MSB of the result flags a hit
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDXW-1:0] ptr);
        logic [IDXW:0] r;
        int            idx;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (v[idx]) begin
                r = {1'b1, idx[IDXW-1:0]};
            end
        end
        return r;
    endfunction

`ifdef ARB_LOCK_EN
    localparam int CNTW = $clog2(LOCK_MAX + 1);

    logic            locked;
    logic [IDXW-1:0] lock_owner;
    logic [CNTW-1:0] lock_cnt;

    // Lock engages on a locked beat, releases on an unlocked beat, an idle owner cycle, or the LOCK_MAX-th beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked     <= 1'b0;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else if (win_found) begin
            if (req_lock[win_idx] && lock_cnt != CNTW'(LOCK_MAX - 1)) begin
                locked     <= 1'b1;
                lock_owner <= win_idx;
                lock_cnt   <= lock_cnt + CNTW'(1);
            end else begin
                locked   <= 1'b0;
                lock_cnt <= '0;
            end
        end else if (locked && !req_valid[lock_owner]) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = (^req_lock) ^ (LOCK_MAX > 0);
`endif

    // Winner selection: lock owner only while locked, otherwise round-robin; nothing granted in reset
    always_comb begin
        rr_choice = rr_pick(req_valid, rr_ptr);
        win_found = rr_choice[IDXW];
        win_idx   = rr_choice[IDXW-1:0];
`ifdef ARB_LOCK_EN
        if (locked) begin
            win_idx   = lock_owner;
            win_found = req_valid[lock_owner];
        end
`endif
        if (!rst) begin
            win_found = 1'b0;
        end
        req_grant = win_found ? (NREQ'(1) << win_idx) : '0;
        sel_we    = req_we[{win_idx, 2'b00} +: 4];
        sel_addr  = req_addr[{win_idx, 5'b00000} +: 32];
        sel_wdata = req_wdata[{win_idx, 5'b00000} +: 32];
    end

    // Round-robin pointer moves just past each winner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (win_found) begin
            rr_ptr <= (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + IDXW'(1);
        end
    end

    // Issue register: drives the memory port the cycle after the grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            S_R_req  <= 1'b0;
            S_W_req  <= 4'b0000;
            S_addr   <= '0;
            S_W_data <= '0;
        end else if (win_found) begin
            S_addr   <= sel_addr;
            S_W_data <= sel_wdata;
            if (sel_we != 4'b0000) begin
                S_W_req <= sel_we;
                S_R_req <= 1'b0;
            end else begin
                S_R_req <= 1'b1;
                S_W_req <= 4'b0000;
            end
        end else begin
            S_R_req <= 1'b0;
            S_W_req <= 4'b0000;
        end
    end

    // Two-stage read tag pipeline lines up requester index with SRAM read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag1_v   <= 1'b0;
            tag1_idx <= '0;
            tag2_v   <= 1'b0;
            tag2_idx <= '0;
        end else begin
            tag1_v   <= win_found && (sel_we == 4'b0000);
            tag1_idx <= win_idx;
            tag2_v   <= tag1_v;
            tag2_idx <= tag1_idx;
        end
    end

    assign rsp_valid = tag2_v ? (NREQ'(1) << tag2_idx) : '0;
    assign rsp_data  = S_R_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;

    logic         clk;
    logic         rst;
    logic [2:0]   req_valid;
    logic [11:0]  req_we;
    logic [95:0]  req_addr;
    logic [95:0]  req_wdata;
    logic [2:0]   req_lock;
    logic [2:0]   req_grant;
    logic [2:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         S_R_req;
    logic [31:0]  S_addr;
    logic [31:0]  S_R_data;
    logic [3:0]   S_W_req;
    logic [31:0]  S_W_data;

    logic [3:0]   we_a   [3];
    logic [31:0]  addr_a [3];
    logic [31:0]  wd_a   [3];

    typedef struct {
        int          due;
        logic [2:0]  oh;
        logic [31:0] data;
    } rsp_t;

    rsp_t  exp_q[$];
    int    cyc;
    int    n_tests;
    int    n_fail;

    logic        prev_v;
    logic [3:0]  prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;

    assign req_we    = {we_a[2], we_a[1], we_a[0]};
    assign req_addr  = {addr_a[2], addr_a[1], addr_a[0]};
    assign req_wdata = {wd_a[2], wd_a[1], wd_a[0]};

    sram_port_arbiter #(.NREQ(3), .LOCK_MAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_lock  (req_lock),
        .req_grant (req_grant),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .S_R_req   (S_R_req),
        .S_addr    (S_addr),
        .S_R_data  (S_R_data),
        .S_W_req   (S_W_req),
        .S_W_data  (S_W_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h1C) ? 32'hA5B6C7D8 : {a[15:0], ~a[15:0]};
    endfunction

    // SRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (S_R_req) S_R_data <= mem_f(S_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic [2:0] exp_g, input string tag);
        rsp_t e;
        int   idx;
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("rsp_valid", {61'd0, rsp_valid}, {61'd0, e.oh});
            check("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
        end else begin
            check("rsp_idle", {61'd0, rsp_valid}, 64'd0);
        end
        if (prev_v) begin
            check("S_R_req", {63'd0, S_R_req}, {63'd0, (prev_we == 4'b0000)});
            check("S_W_req", {60'd0, S_W_req}, {60'd0, prev_we});
            check("S_addr", {32'd0, S_addr}, {32'd0, prev_addr});
            if (prev_we != 4'b0000) check("S_W_data", {32'd0, S_W_data}, {32'd0, prev_wdata});
        end else begin
            check("S_R_req_idle", {63'd0, S_R_req}, 64'd0);
            check("S_W_req_idle", {60'd0, S_W_req}, 64'd0);
        end
        check(tag, {61'd0, req_grant}, {61'd0, exp_g});
        prev_v = (exp_g != 3'b000);
        if (prev_v) begin
            idx = exp_g[0] ? 0 : (exp_g[1] ? 1 : 2);
            prev_we    = we_a[idx];
            prev_addr  = addr_a[idx];
            prev_wdata = wd_a[idx];
            if (we_a[idx] == 4'b0000) begin
                e.due  = cyc + 2;
                e.oh   = exp_g;
                e.data = mem_f(addr_a[idx]);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_valid = 3'b000;
        req_lock  = 3'b000;
    endtask

    logic [2:0] rr3 [3];
    logic [2:0] eg;

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0;
        prev_v = 1'b0; prev_we = 4'b0; prev_addr = '0; prev_wdata = '0;
        S_R_data = 32'h0;
        rr3[0] = 3'b001; rr3[1] = 3'b010; rr3[2] = 3'b100;
        for (int i = 0; i < 3; i++) begin
            we_a[i]   = 4'b0000;
            addr_a[i] = 32'h100 + 32'(i) * 32'h10;
            wd_a[i]   = 32'hDEAD0000 + 32'(i);
        end
        rst = 1'b0;
        req_valid = 3'b111;
        req_lock  = 3'b000;

        // reset state with requests pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", {61'd0, req_grant}, 64'd0);
        check("rst_rsp_valid", {61'd0, rsp_valid}, 64'd0);
        check("rst_S_R_req", {63'd0, S_R_req}, 64'd0);
        check("rst_S_addr", {32'd0, S_addr}, 64'd0);
        check("rst_S_W_req", {60'd0, S_W_req}, 64'd0);
        check("rst_S_W_data", {32'd0, S_W_data}, 64'd0);
        check("rst_rsp_data", {32'd0, rsp_data}, {32'd0, S_R_data});
        @(posedge clk); #1;
        rst = 1'b1;

        // reset mid-read: grant at t, reset at t+1, nothing returns at t+2
        step(3'b001, "grant_pre_rst");
        rst = 1'b0;
        set_idle();
        exp_q.delete();
        prev_v = 1'b0;
        @(negedge clk);
        check("midrst_S_R_req", {63'd0, S_R_req}, 64'd0);
        check("midrst_S_addr", {32'd0, S_addr}, 64'd0);
        check("midrst_grant", {61'd0, req_grant}, 64'd0);
        @(posedge clk); #1;
        step(3'b000, "midrst_hold");
        rst = 1'b1;

        // round-robin with all requesters reading continuously; rr_ptr restarted at 0
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) step(rr3[k % 3], "rr_grant");
        set_idle();
        step(3'b000, "drain");
        step(3'b000, "drain");

        // single read from requester 1
        addr_a[1] = 32'h1C;
        req_valid = 3'b010;
        step(3'b010, "single_read");
        set_idle();
        step(3'b000, "drain");
        step(3'b000, "drain");
        addr_a[1] = 32'h110;

        // write from requester 2: no response expected
        we_a[2] = 4'b1111; addr_a[2] = 32'h40; wd_a[2] = 32'h01020304;
        req_valid = 3'b100;
        step(3'b100, "write_grant");
        set_idle();
        step(3'b000, "drain");
        step(3'b000, "drain");
        we_a[2] = 4'b0000; addr_a[2] = 32'h120;

        // 7-beat burst from requester 0, lock on beats 1-6, contenders 1 and 2
        for (int k = 0; k < 9; k++) begin
            req_valid = (k < 7) ? 3'b111 : 3'b110;
            req_lock  = (k < 6) ? 3'b001 : 3'b000;
`ifdef ARB_LOCK_EN
            eg = (k < 7) ? 3'b001 : rr3[k - 6];
`else
            eg = rr3[k % 3];
`endif
            step(eg, "burst7_grant");
        end
        set_idle();
        step(3'b000, "drain");
        step(3'b000, "drain");

        // lock held beyond LOCK_MAX: capped at 16 beats, then round-robin from 1
        for (int k = 0; k < 18; k++) begin
            req_valid = 3'b111;
            req_lock  = 3'b001;
`ifdef ARB_LOCK_EN
            eg = (k < 16) ? 3'b001 : rr3[k - 15];
`else
            eg = rr3[k % 3];
`endif
            step(eg, "lockmax_grant");
        end
        set_idle();
        step(3'b000, "drain");
        step(3'b000, "drain");
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-ported feature-map SRAM between up to NREQ accelerator engines, for example the convolution engine, the pooling engine and the host loader. Each engine gets its own valid/grant request channel. The block drives one memory port with the same R_req/addr/R_data/W_req/W_data signalling the engines already use. Arbitration is round-robin, with optional burst locking so a line-buffer fill (7 consecutive words) completes uninterrupted.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- LOCK_MAX, 16, maximum consecutive grants one requester may hold under lock

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has an access pending; fields below held stable until granted
- req_we  in  4*NREQ  byte write enables of requester i; 4'b0000 means read
- req_addr  in  32*NREQ  byte address of requester i
- req_wdata  in  32*NREQ  write data of requester i
- req_lock  in  NREQ  request to keep the grant after this beat
- req_grant  out  NREQ  one-hot; combinational; access accepted this cycle
- rsp_valid  out  NREQ  one-hot; read data for requester i is on rsp_data
- rsp_data  out  32  read data, passthrough of S_R_data
- S_R_req  out  1  memory read request
- S_addr  out  32  memory address
- S_R_data  in  32  memory read data, valid one cycle after S_R_req is sampled
- S_W_req  out  4  memory byte write enables
- S_W_data  out  32  memory write data

## Operation
- **Grant rule:**
  - At most one requester is granted per cycle.
  - With no lock active, the winner is the lowest index at or after rr_ptr (wrapping NREQ-1 to 0) with req_valid=1.
  - After a grant to i, rr_ptr becomes (i+1) mod NREQ.
  - rr_ptr resets to 0.
- **Lock:**
  - If granted i has req_lock=1, lock_owner becomes i and lock_cnt increments.
  - While locked, only i can be granted. Other requesters wait even if i is idle.
  - The lock releases in any of these cases:
    - i is granted with req_lock=0;
    - req_valid[i]=0 for one full cycle;
    - lock_cnt reaches LOCK_MAX. The LOCK_MAX-th beat is granted, then arbitration resumes from (i+1).
  - lock_cnt resets to 0 on release.
- **Issue register:**
  - On the granted edge, S_addr and S_W_data load the winner's fields.
  - If req_we≠0: S_W_req<=req_we and S_R_req<=0.
  - Otherwise: S_R_req<=1 and S_W_req<=0.
  - With no grant: S_R_req<=0 and S_W_req<=0; S_addr and S_W_data hold.
- **Response routing:**
  - A read grant pushes tag {1, i} into a 2-stage pipeline.
  - rsp_valid[i]=1 when the stage-2 tag is valid and holds index i.
  - rsp_data=S_R_data at all times.
  - Writes produce no response.
- **Reset:** async assertion clears all outputs to 0 and clears rr_ptr, lock state and tag pipeline. Any in-flight read is dropped: no rsp_valid after reset.

## Timing
- Grant in cycle t (req_valid[i] & req_grant[i]).
- S_* is driven in cycle t+1.
- For reads, rsp_valid[i] and data appear in cycle t+2.
- Throughput is one access per cycle. Back-to-back reads from different requesters return in grant order with no bubbles.
- Reset values: req_grant=0, rsp_valid=0, rsp_data=S_R_data, S_R_req=0, S_addr=0, S_W_req=0, S_W_data=0.
- A requester may deassert req_valid on the cycle after its grant, or keep it high for the next beat.
- Simultaneous release and new request: on the cycle a lock releases, the next grant (earliest cycle t+1) follows normal round-robin from (owner+1).
- All req_valid=0: no grant, rr_ptr unchanged.

## Configuration
- **ARB_LOCK_EN defined:** locking as described; lock_owner and lock_cnt are present.
- **ARB_LOCK_EN undefined:** req_lock is ignored, no lock state is synthesized, and every grant is pure round-robin.

## Test plan
- **Reset:** rst=0 mid-read (grant at t, reset at t+1) -> all outputs 0 and no rsp_valid at t+2. After release, the first grant with all req_valid=1 goes to requester 0.
- **Single read:** requester 1 reads addr 0x1C; the memory model returns 0xA5B6C7D8 -> req_grant=3'b010 at t, S_R_req=1/S_addr=0x1C at t+1, rsp_valid=3'b010 with rsp_data=0xA5B6C7D8 at t+2.
- **Round-robin fairness:** all three requesters hold continuous reads -> grant sequence 0,1,2,0,1,2 with one grant per cycle, and each rsp_valid is routed to the matching index 2 cycles later.
- **Write:** requester 2 writes we=4'b1111, addr 0x40, data 0x01020304 -> S_W_req=4'b1111, S_W_data=0x01020304, S_R_req=0 at t+1; no rsp_valid.
- **Lock (ARB_LOCK_EN):**
  - Requester 0 issues 7 reads with req_lock=1 on beats 1-6 while 1 and 2 request -> seven consecutive grants to 0, then 1, 2.
  - With req_lock held for 20 beats -> exactly 16 consecutive grants to 0, then a grant to 1.
- **Lock compiled out:** same stimulus without ARB_LOCK_EN -> grants interleave 0,1,2,0,...
